// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: instruction field encodings,
// register select codes and Status/Cause bit positions.
package cp0_pkg;

  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [4:0] RS_MFC0    = 5'b00000;
  localparam logic [4:0] RS_MTC0    = 5'b00100;
  localparam logic [5:0] FUNCT_ERET = 6'b011000;

  localparam logic [2:0] SEL_EPC     = 3'd0;
  localparam logic [2:0] SEL_STATUS  = 3'd1;
  localparam logic [2:0] SEL_MASK    = 3'd2;
  localparam logic [2:0] SEL_CAUSE   = 3'd3;
  localparam logic [2:0] SEL_COUNT   = 3'd4;
  localparam logic [2:0] SEL_COMPARE = 3'd5;

  localparam int ST_IE          = 0;
  localparam int ST_EXL         = 1;
  localparam int CAUSE_PEND_LSB = 16;
  localparam int CODE_W         = 5;

endpackage

// File: rtl/cp0_prio_enc.sv
// Lowest-index-first priority encoder.
//   req_i   : request vector
//   valid_o : any request set
//   idx_o   : index of the lowest set request (0 when none)
module cp0_prio_enc #(
  parameter int W     = 4,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cp0_multi.sv
// CP0 coprocessor with multiple level-sensitive exception sources plus
// an internal Count/Compare timer source at index NUM_SRC.
//   clk, reset          : clock, synchronous active-low reset
//   exp_src             : external exception request levels
//   enable, instruction : CP0 instruction strobe and word (mfc0/mtc0/eret)
//   pc_in, din          : PC of current instruction, mtc0 write data
//   dout, ex_reg_write  : mfc0 read data and GPR write enable
//   pc_out              : redirect target (handler on take, else EPC)
//   is_eret, exp_take   : eret decoded, one-cycle exception redirect pulse
//   has_exp, exp_block  : unmasked exception pending, in-handler (EXL)
module cp0_multi
  import cp0_pkg::*;
#(
  parameter int          NUM_SRC      = 3,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exp_src,
  input  logic               enable,
  input  logic [31:0]        instruction,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic [31:0]        pc_out,
  output logic               ex_reg_write,
  output logic               is_eret,
  output logic               exp_take,
  output logic               has_exp,
  output logic               exp_block
);

  localparam int NS = NUM_SRC + 1;

  logic [31:0]       epc_q, epc_d, count_q, count_d, compare_q, compare_d;
  logic              ie_q, ie_d, exl_q, exl_d, take_q;
  logic [NS-1:0]     mask_q, mask_d, pend_q, pend_d;
  logic [CODE_W-1:0] code_q, code_d, pend_idx;

  // Decode
  logic       cop0, mfc0, mtc0, eret;
  logic [2:0] sel;
  logic       unused_instr;

  assign cop0 = enable && (instruction[31:26] == OP_COP0);
  assign mfc0 = cop0 && (instruction[25:21] == RS_MFC0);
  assign mtc0 = cop0 && (instruction[25:21] == RS_MTC0);
  assign eret = cop0 && instruction[25] && (instruction[5:0] == FUNCT_ERET);
  assign sel  = instruction[13:11];
  assign unused_instr = ^{instruction[20:14], instruction[10:6]};

  logic timer_hit, take;

  cp0_prio_enc #(.W(NS), .IDX_W(CODE_W)) u_prio (
    .req_i   (pend_q & mask_q),
    .valid_o (has_exp),
    .idx_o   (pend_idx)
  );

  assign timer_hit = (compare_q != '0) && (count_q == compare_q);
  // Status is sampled pre-write; eret holds off the take for one edge.
  assign take      = has_exp && ie_q && !exl_q && !eret;

  always_comb begin
    epc_d     = epc_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    code_d    = code_q;
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    if (mtc0) begin
      case (sel)
        SEL_EPC:     epc_d = din;
        SEL_STATUS:  begin
          ie_d  = din[ST_IE];
          exl_d = din[ST_EXL];
        end
        SEL_MASK:    mask_d = din[NS-1:0];
        SEL_CAUSE:   pend_d = pend_d & ~din[CAUSE_PEND_LSB +: NS];
        SEL_COUNT:   count_d = din;
        SEL_COMPARE: begin
          compare_d       = din;
          pend_d[NUM_SRC] = 1'b0;
        end
        default: ;
      endcase
    end
    if (eret) exl_d = 1'b0;
    // Take overrides a coincident mtc0 to EPC/EXL; IE keeps the written value.
    if (take) begin
      epc_d            = pc_in;
      exl_d            = 1'b1;
      code_d           = pend_idx;
      pend_d[pend_idx] = 1'b0;
    end
    // New requests win over any clear in the same cycle.
    pend_d = pend_d | {timer_hit, exp_src};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_q     <= '0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      code_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      take_q    <= 1'b0;
    end else begin
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      code_q    <= code_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      take_q    <= take;
    end
  end

  // Read mux
  logic [31:0] cause_rd;
  always_comb begin
    cause_rd                        = '0;
    cause_rd[CODE_W-1:0]            = code_q;
    cause_rd[CAUSE_PEND_LSB +: NS]  = pend_q;
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_EPC:     dout = epc_q;
      SEL_STATUS:  dout = {30'd0, exl_q, ie_q};
      SEL_MASK:    dout = 32'(mask_q);
      SEL_CAUSE:   dout = cause_rd;
      SEL_COUNT:   dout = count_q;
      SEL_COMPARE: dout = compare_q;
      default:     dout = '0;
    endcase
  end

  assign ex_reg_write = mfc0;
  assign is_eret      = eret;
  assign exp_take     = take_q;
  assign exp_block    = exl_q;
  assign pc_out       = take_q ? HANDLER_ADDR : epc_q;

endmodule

// File: tb/tb_cp0_multi.sv
module tb_cp0_multi;

  localparam int          NSRC    = 3;
  localparam logic [31:0] HANDLER = 32'h0000_0080;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] exp_src;
  logic            enable;
  logic [31:0]     instruction, pc_in, din;
  logic [31:0]     dout, pc_out;
  logic            ex_reg_write, is_eret, exp_take, has_exp, exp_block;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  // Scoreboard: expected EPC of each exception take, in order.
  logic [31:0] sb_q[$];
  logic [31:0] sb_e;

  always #20 clk = ~clk;

  cp0_multi #(.NUM_SRC(NSRC), .HANDLER_ADDR(HANDLER)) dut (
    .clk          (clk),
    .reset        (reset),
    .exp_src      (exp_src),
    .enable       (enable),
    .instruction  (instruction),
    .pc_in        (pc_in),
    .din          (din),
    .dout         (dout),
    .pc_out       (pc_out),
    .ex_reg_write (ex_reg_write),
    .is_eret      (is_eret),
    .exp_take     (exp_take),
    .has_exp      (has_exp),
    .exp_block    (exp_block)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_mfc0(input logic [2:0] s);
    return {6'b010000, 5'b00000, 5'd0, 2'b00, s, 11'd0};
  endfunction
  function automatic logic [31:0] i_mtc0(input logic [2:0] s);
    return {6'b010000, 5'b00100, 5'd0, 2'b00, s, 11'd0};
  endfunction
  function automatic logic [31:0] i_eret();
    return {6'b010000, 1'b1, 19'd0, 6'b011000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [2:0] s, input logic [31:0] v);
    enable = 1'b1; instruction = i_mtc0(s); din = v;
    step();
    enable = 1'b0; instruction = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] s, input logic [31:0] e);
    enable = 1'b1; instruction = i_mfc0(s);
    #1;
    chk(tag, dout, e);
    chk({tag, "_we"}, 32'(ex_reg_write), 32'd1);
    enable = 1'b0; instruction = '0;
  endtask

  task automatic do_eret(input logic [31:0] exp_epc);
    enable = 1'b1; instruction = i_eret();
    #1;
    chk("eret_dec", 32'(is_eret), 32'd1);
    chk("eret_pc", pc_out, exp_epc);
    step();
    enable = 1'b0; instruction = '0;
    chk("eret_exl", 32'(exp_block), 32'd0);
    chk("eret_notake", 32'(exp_take), 32'd0);
  endtask

  task automatic wait_take(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      step();
      cnt++;
      if (exp_take === 1'b1) return;
    end
    chk("take_timeout", 32'd0, 32'd1);
  endtask

  // Take monitor: handler redirect during the pulse, single-cycle pulse,
  // then pc_out falls back to the captured EPC.
  always @(posedge clk) begin
    #2;
    if (exp_take === 1'b1) begin
      if (sb_q.size() == 0) chk("unexp_take", 32'd1, 32'd0);
      else begin
        sb_e = sb_q.pop_front();
        chk("take_pc", pc_out, HANDLER);
        chk("take_exl", 32'(exp_block), 32'd1);
        @(posedge clk);
        #2;
        chk("take_pulse", 32'(exp_take), 32'd0);
        chk("take_epc", pc_out, sb_e);
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; instruction = '0;
    pc_in = '0; din = '0; exp_src = '0;
    repeat (2) step();
    chk("rst_take", 32'(exp_take), 32'd0);
    chk("rst_hexp", 32'(has_exp), 32'd0);
    chk("rst_exl", 32'(exp_block), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_we", 32'(ex_reg_write), 32'd0);
    for (int s = 0; s < 8; s++) rd("rst_rd", 3'(s), 32'd0);
    reset = 1'b1;
    step();

    // Single source take
    mtc0(3'd2, 32'hF);
    mtc0(3'd1, 32'h1);
    pc_in = 32'hDEAD_BEEF; exp_src = 3'b010; sb_q.push_back(32'hDEAD_BEEF);
    step();
    exp_src = '0;
    chk("t1_hexp", 32'(has_exp), 32'd1);
    wait_take(5, n);
    chk("t1_lat", 32'(n), 32'd1);
    step();
    rd("t1_epc", 3'd0, 32'hDEAD_BEEF);
    rd("t1_cause", 3'd3, 32'h1);
    chk("t1_exl", 32'(exp_block), 32'd1);

    // Two simultaneous sources: lowest first, other stays pending
    do_eret(32'hDEAD_BEEF);
    pc_in = 32'h1000; exp_src = 3'b101; sb_q.push_back(32'h1000);
    step();
    exp_src = '0;
    wait_take(5, n);
    chk("t2_lat", 32'(n), 32'd1);
    chk("t2_hexp", 32'(has_exp), 32'd1);
    step();
    rd("t2_cause0", 3'd3, 32'h0004_0000);
    pc_in = 32'h2000; sb_q.push_back(32'h2000);
    do_eret(32'h1000);
    wait_take(5, n);
    chk("t2_lat2", 32'(n), 32'd1);
    step();
    rd("t2_epc", 3'd0, 32'h2000);
    rd("t2_cause2", 3'd3, 32'h2);

    // eret coincident with a new unmasked request
    pc_in = 32'h3000; exp_src = 3'b010; sb_q.push_back(32'h3000);
    do_eret(32'h2000);
    exp_src = '0;
    chk("t6_hexp", 32'(has_exp), 32'd1);
    wait_take(5, n);
    chk("t6_lat", 32'(n), 32'd1);
    step();
    rd("t6_cause", 3'd3, 32'h1);
    do_eret(32'h3000);

    // Masked source, write-1-to-clear, set-beats-clear, field masking
    mtc0(3'd2, 32'h0);
    exp_src = 3'b001;
    step();
    exp_src = '0;
    chk("t3_hexp", 32'(has_exp), 32'd0);
    step(); step();
    chk("t3_notake", 32'(exp_take), 32'd0);
    rd("t3_cause", 3'd3, 32'h0001_0001);
    exp_src = 3'b001;
    mtc0(3'd3, 32'h0001_0000);
    exp_src = '0;
    rd("t3_setwin", 3'd3, 32'h0001_0001);
    mtc0(3'd3, 32'h0001_0000);
    rd("t3_w1c", 3'd3, 32'h1);
    mtc0(3'd1, 32'hFFFF_FFF1);
    rd("t3_status", 3'd1, 32'h1);
    mtc0(3'd2, 32'hFFFF_FFF0);
    rd("t3_mask", 3'd2, 32'h0);
    mtc0(3'd6, 32'h1234);
    rd("t3_sel6", 3'd6, 32'h0);
    rd("t3_sel7", 3'd7, 32'h0);
    mtc0(3'd4, 32'hFFFF_FFFF);
    rd("t3_cnt_max", 3'd4, 32'hFFFF_FFFF);
    step();
    rd("t3_cnt_wrap", 3'd4, 32'h0);

    // Timer source
    mtc0(3'd5, 32'd5);
    mtc0(3'd4, 32'd0);
    rd("t4_cnt0", 3'd4, 32'd0);
    rd("t4_cmp", 3'd5, 32'd5);
    mtc0(3'd2, 32'h8);
    mtc0(3'd1, 32'h1);
    pc_in = 32'h4000; sb_q.push_back(32'h4000);
    wait_take(20, n);
    chk("t4_lat", 32'(n), 32'd5);
    step();
    rd("t4_cause", 3'd3, 32'h3);
    mtc0(3'd4, 32'd4);
    step(); step();
    rd("t4_tpend", 3'd3, 32'h0008_0003);
    chk("t4_hexp", 32'(has_exp), 32'd1);
    mtc0(3'd5, 32'd0);
    rd("t4_tclr", 3'd3, 32'h3);
    chk("t4_hexp0", 32'(has_exp), 32'd0);

    // Reset mid-handler with pending work
    exp_src = 3'b001;
    step();
    exp_src = '0;
    rd("t5_pend", 3'd3, 32'h0001_0003);
    reset = 1'b0; exp_src = 3'b001;
    step();
    exp_src = '0;
    chk("t5_take", 32'(exp_take), 32'd0);
    chk("t5_exl", 32'(exp_block), 32'd0);
    chk("t5_hexp", 32'(has_exp), 32'd0);
    chk("t5_pc", pc_out, 32'd0);
    for (int s = 0; s < 8; s++) rd("t5_rd", 3'(s), 32'd0);
    reset = 1'b1;
    step(); step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_multi.md
CP0_MULTI -- requirements
Module: cp0_multi

Interface
REQ-001 Parameter NUM_SRC, default 3: external exception sources, legal 1..15; timer is an extra internal source at index NUM_SRC.
REQ-002 Parameter HANDLER_ADDR, default 32'h0000_0080: exception vector.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-005 exp_src  in  NUM_SRC  level exception requests.
REQ-006 enable  in  1  CP0 instruction valid strobe.
REQ-007 instruction  in  32  current instruction.
REQ-008 pc_in  in  32  PC of current instruction.
REQ-009 din  in  32  mtc0 write data.
REQ-010 dout  out  32  mfc0 read data.
REQ-011 pc_out  out  32  redirect target.
REQ-012 ex_reg_write  out  1  GPR write for mfc0.
REQ-013 is_eret  out  1  eret decoded.
REQ-014 exp_take  out  1  one-cycle exception redirect pulse.
REQ-015 has_exp  out  1  unmasked exception pending.
REQ-016 exp_block  out  1  in-handler (EXL) flag.

Function
REQ-017 Decode (all require enable=1 and instruction[31:26]=6'b010000): mfc0 = rs 5'b00000; mtc0 = rs 5'b00100; eret = instruction[25]=1 and funct 6'b011000.
REQ-018 sel = instruction[13:11]: 0 EPC, 1 Status, 2 Mask, 3 Cause, 4 Count, 5 Compare; sel 6/7 read 0 and ignore writes.
REQ-019 Status: bit0 IE, bit1 EXL, other bits read 0; Mask: bits[NUM_SRC:0] enable, others read 0.
REQ-020 Cause: bits[4:0] last taken source index; bits[16+NUM_SRC:16] pending vector pend; mtc0 to Cause is write-1-to-clear on pend only.
REQ-021 dout = combinational mux of selected register; ex_reg_write = mfc0.
REQ-022 pend[i] set each cycle exp_src[i]=1; set has priority over any clear in the same cycle.
REQ-023 Count increments by 1 every cycle, wraps 32'hFFFF_FFFF to 0; mtc0 to Count loads din instead of incrementing.
REQ-024 pend[NUM_SRC] set when Compare!=0 and Count==Compare; mtc0 to Compare clears it.
REQ-025 has_exp = |(pend & mask), combinational.
REQ-026 Take condition at edge: has_exp & IE & ~EXL & ~eret; then EPC<=pc_in, EXL<=1, code<=lowest set index of pend&mask, pend[code] cleared (subject to REQ-022), exp_take=1 for exactly the following cycle.
REQ-027 pc_out = HANDLER_ADDR while exp_take=1, else EPC when is_eret=1, else EPC.
REQ-028 eret at edge: EXL<=0; pending exceptions are taken no earlier than the next edge.
REQ-029 mtc0 to Status/EPC coincident with take: take wins for EXL and EPC; IE takes din[0]; take evaluated with pre-write Status.
REQ-030 exp_block = EXL; further exceptions while EXL=1 remain pending, not lost.

Reset
REQ-031 reset=0 at edge: EPC, Status, Mask, pend, code, Count, Compare <= 0; exp_take <= 0; dominates all other updates that cycle.
REQ-032 After reset: dout=0 for all sel, has_exp=0, exp_block=0, pc_out=0.

Structure
REQ-033 Package cp0_pkg holds sel constants, opcode/rs/funct constants, Status/Cause bit positions.
REQ-034 Sub-module cp0_prio_enc: parametrised lowest-index-first priority encoder (valid + index).

Verification
REQ-035 Reset, then mtc0 Mask=0xF, Status=0x1; pulse exp_src[1] with pc_in=0xDEAD_BEEF -> exp_take 1 cycle, pc_out=0x80, EPC=0xDEAD_BEEF, Cause[4:0]=1, exp_block=1.
REQ-036 exp_src=3'b101 same cycle -> code 0 taken, pend[2] still set, has_exp=1; eret -> pc_out=EPC, next edge takes code 2.
REQ-037 Mask=0, exp_src[0] pulse -> has_exp=0, no exp_take; mtc0 Cause din=0x1_0000 -> pend[0] cleared.
REQ-038 mtc0 Compare=5, Count=0, Mask=0x8, Status=0x1 -> exp_take follows Count==5; mtc0 Compare clears timer pend.
REQ-039 reset=0 mid-handler (EXL=1, pend nonzero) -> all registers 0 next cycle, exp_take=0.
REQ-040 eret coincident with pending unmasked exp_src -> no take that edge, take next edge.
